// File: rtl/de_write_combiner.sv
// Merges consecutive byte writes from the draw engine into masked word writes, buffers them in a
// small FIFO and drains them to memory. Optional WC_STATS_EN adds merge/write counters.
module de_write_combiner #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned FLUSH_CYCLES = 16,
  parameter int unsigned ADDR_W       = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              de_req,
  output logic              de_ack,
  input  logic [ADDR_W-1:0] de_addr,
  input  logic [3:0]        de_nbyte,
  input  logic              de_rnw,
  input  logic [31:0]       de_w_data,
  output logic [31:0]       de_r_data,
  input  logic              flush,
  output logic              idle,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_nbyte,
  output logic              mem_rnw,
  output logic [31:0]       mem_w_data,
`ifdef WC_STATS_EN
  output logic [15:0]       stat_merges,
  output logic [15:0]       stat_mem_writes,
`endif
  input  logic [31:0]       mem_r_data
);

  localparam int unsigned PtrW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned TimerW = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {StAccept, StAcked, StRdDrain, StRdWait} state_e;

  state_e state_q, state_d;

  logic              de_ack_q, de_ack_d;
  logic [31:0]       de_r_data_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [3:0]        rd_nbyte_q;
  logic              rd_load;

  logic              cr_valid_q, cr_valid_d;
  logic [ADDR_W-1:0] cr_addr_q, cr_addr_d;
  logic [3:0]        cr_nbyte_q, cr_nbyte_d;
  logic [31:0]       cr_data_q, cr_data_d;
  logic [TimerW-1:0] timer_q, timer_d;

  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [3:0]        fifo_nbyte_q [FIFO_DEPTH];
  logic [31:0]       fifo_data_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]     fifo_cnt_q;

  logic fifo_empty, fifo_full, pop, push, can_push;
  logic wr_cap, rd_cap, any_lane, same_addr, timer_hit, want_push, merge_evt;

  assign fifo_empty = (fifo_cnt_q == '0);
  assign fifo_full  = (fifo_cnt_q == (PtrW+1)'(FIFO_DEPTH));
  // mem_ack during a read belongs to the read, never to the (empty) FIFO
  assign pop        = mem_ack && !fifo_empty && (state_q != StRdWait);
  assign can_push   = !fifo_full || pop;

  assign wr_cap     = (state_q == StAccept) && de_req && !de_rnw && can_push;
  assign rd_cap     = (state_q == StAccept) && de_req && de_rnw;
  assign any_lane   = ~&de_nbyte;
  assign same_addr  = cr_valid_q && (cr_addr_q == de_addr);
  assign timer_hit  = cr_valid_q && (timer_q == TimerW'(FLUSH_CYCLES - 1));
  assign merge_evt  = wr_cap && any_lane && same_addr;
  assign want_push  = (cr_nbyte_q == 4'b0000) || flush || timer_hit || rd_cap ||
                      (state_q == StRdDrain);

  // Combine register and flush timer
  always_comb begin
    cr_valid_d = cr_valid_q;
    cr_addr_d  = cr_addr_q;
    cr_nbyte_d = cr_nbyte_q;
    cr_data_d  = cr_data_q;
    timer_d    = timer_q;
    push       = 1'b0;
    if (wr_cap) begin
      timer_d = '0;
      if (any_lane) begin
        if (same_addr) begin
          for (int i = 0; i < 4; i++) begin
            if (!de_nbyte[i]) begin
              cr_data_d[8*i +: 8] = de_w_data[8*i +: 8];
              cr_nbyte_d[i]       = 1'b0;
            end
          end
        end else begin
          push       = cr_valid_q;
          cr_valid_d = 1'b1;
          cr_addr_d  = de_addr;
          cr_nbyte_d = de_nbyte;
          cr_data_d  = de_w_data;
        end
      end
    end else if (cr_valid_q) begin
      if (want_push && can_push) begin
        push       = 1'b1;
        cr_valid_d = 1'b0;
        timer_d    = '0;
      end else if (!timer_hit) begin
        timer_d = timer_q + TimerW'(1);
      end
    end else begin
      timer_d = '0;
    end
  end

  // Transfer FSM
  always_comb begin
    state_d  = state_q;
    de_ack_d = 1'b0;
    rd_load  = 1'b0;
    unique case (state_q)
      StAccept: begin
        if (wr_cap) begin
          state_d  = StAcked;
          de_ack_d = 1'b1;
        end else if (rd_cap) begin
          state_d = StRdDrain;
        end
      end
      StAcked: state_d = StAccept;
      StRdDrain: begin
        if (!cr_valid_q && fifo_empty) begin
          state_d = StRdWait;
          rd_load = 1'b1;
        end
      end
      StRdWait: begin
        if (mem_ack) begin
          state_d  = StAcked;
          de_ack_d = 1'b1;
        end
      end
      default: state_d = StAccept;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StAccept;
      de_ack_q    <= 1'b0;
      de_r_data_q <= '0;
      rd_addr_q   <= '0;
      rd_nbyte_q  <= 4'b1111;
      cr_valid_q  <= 1'b0;
      cr_addr_q   <= '0;
      cr_nbyte_q  <= 4'b1111;
      cr_data_q   <= '0;
      timer_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      de_ack_q   <= de_ack_d;
      cr_valid_q <= cr_valid_d;
      cr_addr_q  <= cr_addr_d;
      cr_nbyte_q <= cr_nbyte_d;
      cr_data_q  <= cr_data_d;
      timer_q    <= timer_d;
      if (state_q == StRdWait && mem_ack) de_r_data_q <= mem_r_data;
      if (rd_load) begin
        rd_addr_q  <= de_addr;
        rd_nbyte_q <= de_nbyte;
      end
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop)      fifo_cnt_q <= fifo_cnt_q + (PtrW+1)'(1);
      else if (pop && !push) fifo_cnt_q <= fifo_cnt_q - (PtrW+1)'(1);
    end
  end

  // Entry storage needs no reset: it is only observed while counted valid
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q]  <= cr_addr_q;
      fifo_nbyte_q[wr_ptr_q] <= cr_nbyte_q;
      fifo_data_q[wr_ptr_q]  <= cr_data_q;
    end
  end

  always_comb begin
    mem_req    = !fifo_empty || (state_q == StRdWait);
    mem_rnw    = 1'b1;
    mem_addr   = '0;
    mem_nbyte  = 4'b1111;
    mem_w_data = '0;
    if (!fifo_empty) begin
      mem_rnw    = 1'b0;
      mem_addr   = fifo_addr_q[rd_ptr_q];
      mem_nbyte  = fifo_nbyte_q[rd_ptr_q];
      mem_w_data = fifo_data_q[rd_ptr_q];
    end else if (state_q == StRdWait) begin
      mem_addr  = rd_addr_q;
      mem_nbyte = rd_nbyte_q;
    end
  end

  assign de_ack    = de_ack_q;
  assign de_r_data = de_r_data_q;
  assign idle      = !cr_valid_q && fifo_empty &&
                     (state_q != StRdDrain) && (state_q != StRdWait);

`ifdef WC_STATS_EN
  logic [15:0] stat_merges_q, stat_mem_writes_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_merges_q     <= '0;
      stat_mem_writes_q <= '0;
    end else if (flush) begin
      stat_merges_q     <= '0;
      stat_mem_writes_q <= '0;
    end else begin
      if (merge_evt && !(&stat_merges_q))   stat_merges_q     <= stat_merges_q + 16'd1;
      if (pop && !(&stat_mem_writes_q))     stat_mem_writes_q <= stat_mem_writes_q + 16'd1;
    end
  end

  assign stat_merges     = stat_merges_q;
  assign stat_mem_writes = stat_mem_writes_q;
`else
  logic unused_stats;
  assign unused_stats = merge_evt;
`endif

endmodule

// File: tb/tb_de_write_combiner.sv
// Scoreboard bench for de_write_combiner: stimulus queues expected memory traffic and read data,
// independent monitors compare what the DUT presents.
module tb_de_write_combiner;

  localparam int unsigned AW = 18;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [3:0]    nb;
    logic [31:0]   d;
  } wr_t;

  logic          clk, rst;
  logic          de_req, de_ack, de_rnw, flush, idle;
  logic [AW-1:0] de_addr, mem_addr;
  logic [3:0]    de_nbyte, mem_nbyte;
  logic [31:0]   de_w_data, de_r_data, mem_w_data, mem_r_data;
  logic          mem_req, mem_ack, mem_rnw;
`ifdef WC_STATS_EN
  logic [15:0]   stat_merges, stat_mem_writes;
`endif

  de_write_combiner #(.FIFO_DEPTH(4), .FLUSH_CYCLES(16), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .de_req     (de_req),
    .de_ack     (de_ack),
    .de_addr    (de_addr),
    .de_nbyte   (de_nbyte),
    .de_rnw     (de_rnw),
    .de_w_data  (de_w_data),
    .de_r_data  (de_r_data),
    .flush      (flush),
    .idle       (idle),
    .mem_req    (mem_req),
    .mem_ack    (mem_ack),
    .mem_addr   (mem_addr),
    .mem_nbyte  (mem_nbyte),
    .mem_rnw    (mem_rnw),
    .mem_w_data (mem_w_data),
`ifdef WC_STATS_EN
    .stat_merges     (stat_merges),
    .stat_mem_writes (stat_mem_writes),
`endif
    .mem_r_data (mem_r_data)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int last_ack = -100;
  int ack_cnt  = 0;
  bit mem_en   = 0;
  bit rd_pending = 0;

  wr_t           exp_wq[$];
  logic [AW-1:0] exp_raq[$];
  logic [31:0]   exp_rdq[$];
  logic [31:0]   mem_model [int];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Memory responder and write/read scoreboard
  initial begin
    mem_ack    = 0;
    mem_r_data = 0;
    forever begin
      @(negedge clk);
      if (mem_ack) begin
        mem_ack = 0;
      end else if (mem_req && mem_en && !rst) begin
        if (!mem_rnw) begin
          if (exp_wq.size() == 0) begin
            check("unexpected_mem_write", {mem_addr, mem_nbyte, mem_w_data}, 64'hdead);
          end else begin
            wr_t e;
            logic [31:0] w;
            e = exp_wq.pop_front();
            check("mem_write", {mem_addr, mem_nbyte, mem_w_data}, {e.addr, e.nb, e.d});
            w = mem_model.exists(int'(mem_addr)) ? mem_model[int'(mem_addr)] : 32'h0;
            for (int i = 0; i < 4; i++) if (!mem_nbyte[i]) w[8*i +: 8] = mem_w_data[8*i +: 8];
            mem_model[int'(mem_addr)] = w;
          end
        end else begin
          if (exp_raq.size() == 0) check("unexpected_mem_read", {46'h0, mem_addr}, 64'hdead);
          else check("rd_addr", {46'h0, mem_addr}, {46'h0, exp_raq.pop_front()});
          check("raw_writes_first", exp_wq.size(), 0);
          mem_r_data = mem_model.exists(int'(mem_addr)) ? mem_model[int'(mem_addr)] : 32'h0;
        end
        mem_ack = 1;
      end
    end
  end

  // de_ack monitor
  initial forever begin
    @(negedge clk);
    if (de_ack) begin
      check("ack_spacing", (cyc - last_ack) >= 2, 1);
      last_ack = cyc;
      ack_cnt++;
      if (rd_pending) begin
        rd_pending = 0;
        if (exp_rdq.size() == 0) check("unexpected_rdata", de_r_data, 64'hdead);
        else check("rd_data", de_r_data, exp_rdq.pop_front());
      end
    end
  end

  task automatic de_write(input logic [AW-1:0] a, input logic [3:0] nb, input logic [31:0] d,
                          input int budget, output bit acked);
    de_req = 1; de_rnw = 0; de_addr = a; de_nbyte = nb; de_w_data = d;
    acked = 0;
    for (int i = 0; i < budget && !acked; i++) begin
      @(negedge clk);
      if (de_ack) acked = 1;
    end
    de_req = 0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (idle) seen = 1;
    end
    check({name, "_idle"}, seen, 1);
    check({name, "_drained"}, exp_wq.size(), 0);
  endtask

  function automatic wr_t mk(input logic [AW-1:0] a, input logic [3:0] nb, input logic [31:0] d);
    wr_t w;
    w.addr = a; w.nb = nb; w.d = d;
    return w;
  endfunction

  logic [AW-1:0] s1_addr;
  logic [3:0]    s1_nb [4];
  logic [31:0]   s1_d  [4];

  initial begin
    bit acked;
    int acks0;
    rst = 1; de_req = 0; de_rnw = 0; de_addr = 0; de_nbyte = 4'hf; de_w_data = 0; flush = 0;
    #1;
    check("rst_de_ack", de_ack, 0);
    check("rst_de_r_data", de_r_data, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_rnw", mem_rnw, 1);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_nbyte", mem_nbyte, 4'hf);
    check("rst_mem_w_data", mem_w_data, 0);
    check("rst_idle", idle, 1);
    repeat (2) @(negedge clk);
    rst = 0;
    mem_en = 1;
    @(negedge clk);

    // Four byte writes to one word merge into a single full-word write
    s1_addr = 18'h00010;
    s1_nb[0] = 4'b1110; s1_nb[1] = 4'b1101; s1_nb[2] = 4'b1011; s1_nb[3] = 4'b0111;
    s1_d[0] = 32'h00000011; s1_d[1] = 32'h00002200; s1_d[2] = 32'h00330000; s1_d[3] = 32'h44000000;
    exp_wq.push_back(mk(s1_addr, 4'b0000, 32'h44332211));
    acks0 = ack_cnt;
    for (int i = 0; i < 4; i++) begin
      de_write(s1_addr, s1_nb[i], s1_d[i], 20, acked);
      check("s1_acked", acked, 1);
    end
    wait_idle("s1", 60);
    check("s1_ack_count", ack_cnt - acks0, 4);
`ifdef WC_STATS_EN
    check("stat_merges", stat_merges, 3);
    check("stat_mem_writes", stat_mem_writes, 1);
    flush = 1;
    @(negedge clk);
    flush = 0;
    check("stat_merges_flush", stat_merges, 0);
    check("stat_mem_writes_flush", stat_mem_writes, 0);
`endif

    // Address change pushes, idle timer flushes the partial word
    exp_wq.push_back(mk(18'd5, 4'b1110, 32'h000000AA));
    exp_wq.push_back(mk(18'd6, 4'b1101, 32'h0000BB00));
    de_write(18'd5, 4'b1110, 32'h000000AA, 20, acked);
    check("s2_ack_a", acked, 1);
    de_write(18'd6, 4'b1101, 32'h0000BB00, 20, acked);
    check("s2_ack_b", acked, 1);
    repeat (10) @(negedge clk);
    check("s2_timer_holds", exp_wq.size(), 1);
    wait_idle("s2", 60);

    // Back-pressure: 4 FIFO entries plus the CR, then the sixth write stalls
    mem_en = 0;
    for (int i = 0; i < 6; i++)
      exp_wq.push_back(mk(18'h30 + AW'(i), 4'b1110, 32'hA0 + 32'(i)));
    for (int i = 0; i < 5; i++) begin
      de_write(18'h30 + AW'(i), 4'b1110, 32'hA0 + 32'(i), 20, acked);
      check("s3_ack", acked, 1);
    end
    de_write(18'h35, 4'b1110, 32'hA5, 30, acked);
    check("s3_stalled", acked, 0);
    check("s3_head", mem_addr, 18'h30);
    mem_en = 1;
    de_write(18'h35, 4'b1110, 32'hA5, 60, acked);
    check("s3_ack_after_drain", acked, 1);
    wait_idle("s3", 80);

    // All lanes disabled: acked, nothing buffered
    de_write(18'h20, 4'b1111, 32'hFFFFFFFF, 20, acked);
    check("nolane_acked", acked, 1);
    @(negedge clk);
    check("nolane_idle", idle, 1);

    // Read after write returns the new data
    exp_wq.push_back(mk(18'd9, 4'b1011, 32'h005A0000));
    de_write(18'd9, 4'b1011, 32'h005A0000, 20, acked);
    check("s4_wr_ack", acked, 1);
    exp_raq.push_back(18'd9);
    exp_rdq.push_back(32'h005A0000);
    rd_pending = 1;
    de_req = 1; de_rnw = 1; de_addr = 18'd9; de_nbyte = 4'b0000;
    acked = 0;
    for (int i = 0; i < 100 && !acked; i++) begin
      @(negedge clk);
      if (de_ack) acked = 1;
    end
    de_req = 0; de_rnw = 0;
    check("s4_rd_ack", acked, 1);
    check("s4_rd_consumed", exp_rdq.size(), 0);
    wait_idle("s4", 40);

    // Reset with three FIFO entries pending discards everything
    mem_en = 0;
    for (int i = 0; i < 4; i++) begin
      de_write(18'h100 + AW'(i), 4'b1110, 32'h11, 20, acked);
      check("s5_ack", acked, 1);
    end
    check("s5_req_before", mem_req, 1);
    #2 rst = 1;
    #1;
    check("s5_req_async", mem_req, 0);
    check("s5_idle_async", idle, 1);
    @(negedge clk);
    rst = 0;
    mem_en = 1;
    repeat (30) @(negedge clk);
    check("s5_no_stale_req", mem_req, 0);
    check("s5_idle_after", idle, 1);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
